// File: rtl/niu_sii_dma_req_tracker.sv
// niu_sii_dma_req_tracker
//
// Passive monitor on the NIU->SII inbound DMA request bus (iol2clk domain).
// It decodes header cycles and follows write payload beats with a
// two-state FSM (IDLE / WDATA). It keeps saturating read, write and bypass
// counters and captures the tag and PA of the last accepted header. It also
// flags protocol, parity and saturation errors. The block never drives the bus.
//
// Optional feature: define NIU_SII_DMA_TRK_PARCHK_EN to enable per-lane even
// parity checking. When the macro is undefined, no parity logic is built,
// err_sticky[2] stays 0 and niu_sii_parity is ignored.
//
// Ports:
//   iol2clk, rst        clock, asynchronous active-high reset
//   enable              monitor enable; 0 forces IDLE and freezes statistics
//   clr_stats           synchronous clear of counters and sticky errors
//   niu_sii_hdr_vld     header cycle valid
//   niu_sii_reqbypass   1 = bypass queue, 0 = ordered queue
//   niu_sii_datareq     request carries data
//   niu_sii_datareq16   16-byte data request
//   niu_sii_data        header / payload data (DATA_W)
//   niu_sii_parity      one even-parity bit per 16-bit lane
//   rd_cnt/wr_cnt/byp_cnt  saturating statistics (CNT_W)
//   hdr_tag, hdr_pa     data[79:64] / data[39:0] of the last accepted header
//   hdr_strobe          one-cycle pulse on header accept
//   wr_done             one-cycle pulse on the final write beat
//   err_sticky          [0] header in payload, [1] reserved encoding,
//                       [2] parity, [3] counter saturation
//   err_pulse           pulse whenever any error is detected this cycle
module niu_sii_dma_req_tracker #(
   parameter int DATA_W        = 128,
   parameter int PAYLOAD_BEATS = 4,
   parameter int CNT_W         = 16
) (
   input  logic                  iol2clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clr_stats,
   input  logic                  niu_sii_hdr_vld,
   input  logic                  niu_sii_reqbypass,
   input  logic                  niu_sii_datareq,
   input  logic                  niu_sii_datareq16,
   input  logic [DATA_W-1:0]     niu_sii_data,
   input  logic [DATA_W/16-1:0]  niu_sii_parity,
   output logic [CNT_W-1:0]      rd_cnt,
   output logic [CNT_W-1:0]      wr_cnt,
   output logic [CNT_W-1:0]      byp_cnt,
   output logic [15:0]           hdr_tag,
   output logic [39:0]           hdr_pa,
   output logic                  hdr_strobe,
   output logic                  wr_done,
   output logic [3:0]            err_sticky,
   output logic                  err_pulse
);

   localparam int LANES = DATA_W / 16;
   localparam int BC_W  = $clog2(PAYLOAD_BEATS + 1);

   localparam logic [BC_W-1:0]  BC_ZERO = {BC_W{1'b0}};
   localparam logic [BC_W-1:0]  BC_ONE  = {{(BC_W-1){1'b0}}, 1'b1};
   localparam logic [BC_W-1:0]  BC_FULL = BC_W'(PAYLOAD_BEATS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WDATA = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [BC_W-1:0] beat_cnt_r;
   logic [BC_W-1:0] beat_cnt_nxt_s;

   logic       accept_s;
   logic       inc_rd_s;
   logic       inc_wr_s;
   logic       inc_byp_s;
   logic       done_s;
   logic       chk_par_s;
   logic       par_err_s;
   logic       sat_s;
   logic [2:0] err_ev_s;
   logic [3:0] err_new_s;

`ifdef NIU_SII_DMA_TRK_PARCHK_EN
   // Returns 1 when any 16-bit lane fails even parity against its parity bit.
   function automatic logic lane_par_err(input logic [DATA_W-1:0] data,
                                         input logic [LANES-1:0]  par);
      logic err;
      err = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         err = err | ((^data[16*i +: 16]) ^ par[i]);
      end
      return err;
   endfunction

   assign par_err_s = lane_par_err(niu_sii_data, niu_sii_parity);
`else
   logic unused_in_s;

   assign par_err_s   = 1'b0;
   // Without parity checking only the tag/PA fields are consumed.
   assign unused_in_s = ^{niu_sii_data, niu_sii_parity};
`endif

   // FSM state and beat counter registers.
   always_ff @(posedge iol2clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         beat_cnt_r <= BC_ZERO;
      end else begin
         state_r    <= state_nxt_s;
         beat_cnt_r <= beat_cnt_nxt_s;
      end
   end

   // Next-state decode plus per-cycle event strobes for the output registers.
   always_comb begin
      state_nxt_s    = state_r;
      beat_cnt_nxt_s = beat_cnt_r;
      accept_s       = 1'b0;
      inc_rd_s       = 1'b0;
      inc_wr_s       = 1'b0;
      done_s         = 1'b0;
      chk_par_s      = 1'b0;
      err_ev_s       = 3'b000;
      if (!enable) begin
         state_nxt_s    = ST_IDLE;
         beat_cnt_nxt_s = BC_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (niu_sii_hdr_vld) begin
                  chk_par_s = 1'b1;
                  case ({niu_sii_datareq, niu_sii_datareq16})
                     2'b00: begin
                        accept_s = 1'b1;
                        inc_rd_s = 1'b1;
                     end
                     2'b10: begin
                        accept_s       = 1'b1;
                        beat_cnt_nxt_s = BC_FULL;
                        state_nxt_s    = ST_WDATA;
                     end
                     2'b11: begin
                        accept_s       = 1'b1;
                        beat_cnt_nxt_s = BC_ONE;
                        state_nxt_s    = ST_WDATA;
                     end
                     default: begin
                        err_ev_s[1] = 1'b1;
                     end
                  endcase
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_WDATA: begin
               // Every WDATA cycle is a beat, even one that carries a
               // stray header; the header itself is only flagged.
               chk_par_s      = 1'b1;
               err_ev_s[0]    = niu_sii_hdr_vld;
               beat_cnt_nxt_s = beat_cnt_r - BC_ONE;
               if (beat_cnt_r == BC_ONE) begin
                  done_s      = 1'b1;
                  inc_wr_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_WDATA;
               end
            end
            default: begin
               state_nxt_s    = ST_IDLE;
               beat_cnt_nxt_s = BC_ZERO;
            end
         endcase
      end
      err_ev_s[2] = chk_par_s & par_err_s;
   end

   // Saturation detection and collection of all error events for this cycle.
   always_comb begin
      inc_byp_s = accept_s & niu_sii_reqbypass;
      sat_s     = (inc_rd_s  & (rd_cnt  == CNT_MAX)) |
                  (inc_wr_s  & (wr_cnt  == CNT_MAX)) |
                  (inc_byp_s & (byp_cnt == CNT_MAX));
      err_new_s = {sat_s, err_ev_s};
   end

   // Registered outputs: pulses, header capture, statistics and errors.
   always_ff @(posedge iol2clk or posedge rst) begin
      if (rst) begin
         hdr_strobe <= 1'b0;
         wr_done    <= 1'b0;
         hdr_tag    <= 16'h0000;
         hdr_pa     <= 40'h00_0000_0000;
         rd_cnt     <= {CNT_W{1'b0}};
         wr_cnt     <= {CNT_W{1'b0}};
         byp_cnt    <= {CNT_W{1'b0}};
         err_sticky <= 4'b0000;
         err_pulse  <= 1'b0;
      end else begin
         hdr_strobe <= accept_s;
         wr_done    <= done_s;
         if (accept_s) begin
            hdr_tag <= niu_sii_data[79:64];
            hdr_pa  <= niu_sii_data[39:0];
         end
         // Clear wins over any increment or error in the same cycle.
         if (clr_stats) begin
            rd_cnt     <= {CNT_W{1'b0}};
            wr_cnt     <= {CNT_W{1'b0}};
            byp_cnt    <= {CNT_W{1'b0}};
            err_sticky <= 4'b0000;
            err_pulse  <= 1'b0;
         end else begin
            if (inc_rd_s && (rd_cnt != CNT_MAX)) begin
               rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (inc_wr_s && (wr_cnt != CNT_MAX)) begin
               wr_cnt <= wr_cnt + CNT_ONE;
            end
            if (inc_byp_s && (byp_cnt != CNT_MAX)) begin
               byp_cnt <= byp_cnt + CNT_ONE;
            end
            err_sticky <= err_sticky | err_new_s;
            err_pulse  <= |err_new_s;
         end
      end
   end

endmodule

// File: tb/tb_niu_sii_dma_req_tracker.sv
// Self-checking bench for niu_sii_dma_req_tracker.
// Two instances share one stimulus stream: u_dut with default counters and
// u_sat with CNT_W=2, so saturation is reached quickly. A transaction-level
// reference model (remaining-beat count, unbounded event counts capped at
// compare time) predicts every output after each clock edge.
module tb_niu_sii_dma_req_tracker;

   localparam int DATA_W = 128;
   localparam int LANES  = DATA_W / 16;
   localparam int PB     = 4;
   localparam int MAX_A  = 65535;
   localparam int MAX_B  = 3;

   logic              iol2clk = 1'b0;
   logic              rst = 1'b1;
   logic              enable = 1'b0;
   logic              clr_stats = 1'b0;
   logic              hdr_vld = 1'b0;
   logic              reqbypass = 1'b0;
   logic              datareq = 1'b0;
   logic              datareq16 = 1'b0;
   logic [DATA_W-1:0] data = '0;
   logic [LANES-1:0]  parity = '0;
   logic              par_bad = 1'b0;

   logic [15:0] rd_a, wr_a, byp_a;
   logic [1:0]  rd_b, wr_b, byp_b;
   logic [15:0] tag_a, tag_b;
   logic [39:0] pa_a, pa_b;
   logic        hs_a, hs_b, wd_a, wd_b, pls_a, pls_b;
   logic [3:0]  err_a, err_b;

   int n_cmp = 0;
   int n_mis = 0;

   // model state
   int          rem, n_rd, n_wr, n_byp;
   logic [15:0] m_tag;
   logic [39:0] m_pa;
   logic        m_hs, m_wd, m_pls_a, m_pls_b;
   logic [3:0]  m_err_a, m_err_b;

   always #5 iol2clk = ~iol2clk;

   niu_sii_dma_req_tracker #(.DATA_W(DATA_W), .PAYLOAD_BEATS(PB), .CNT_W(16)) u_dut (
      .iol2clk(iol2clk), .rst(rst), .enable(enable), .clr_stats(clr_stats),
      .niu_sii_hdr_vld(hdr_vld), .niu_sii_reqbypass(reqbypass),
      .niu_sii_datareq(datareq), .niu_sii_datareq16(datareq16),
      .niu_sii_data(data), .niu_sii_parity(parity),
      .rd_cnt(rd_a), .wr_cnt(wr_a), .byp_cnt(byp_a),
      .hdr_tag(tag_a), .hdr_pa(pa_a), .hdr_strobe(hs_a), .wr_done(wd_a),
      .err_sticky(err_a), .err_pulse(pls_a));

   niu_sii_dma_req_tracker #(.DATA_W(DATA_W), .PAYLOAD_BEATS(PB), .CNT_W(2)) u_sat (
      .iol2clk(iol2clk), .rst(rst), .enable(enable), .clr_stats(clr_stats),
      .niu_sii_hdr_vld(hdr_vld), .niu_sii_reqbypass(reqbypass),
      .niu_sii_datareq(datareq), .niu_sii_datareq16(datareq16),
      .niu_sii_data(data), .niu_sii_parity(parity),
      .rd_cnt(rd_b), .wr_cnt(wr_b), .byp_cnt(byp_b),
      .hdr_tag(tag_b), .hdr_pa(pa_b), .hdr_strobe(hs_b), .wr_done(wd_b),
      .err_sticky(err_b), .err_pulse(pls_b));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int cap(input int n, input int m);
      return (n > m) ? m : n;
   endfunction

   // Reference model: one call per rising clock edge using the sampled inputs.
   task automatic model_step();
      logic [2:0] ev;
      logic inc_rd, inc_wr, inc_byp, sat_a, sat_b;
      ev = 3'b000; inc_rd = 1'b0; inc_wr = 1'b0; inc_byp = 1'b0;
      m_hs = 1'b0; m_wd = 1'b0;
      if (rst) begin
         rem = 0; n_rd = 0; n_wr = 0; n_byp = 0;
         m_tag = 16'h0; m_pa = 40'h0;
         m_err_a = 4'h0; m_err_b = 4'h0; m_pls_a = 1'b0; m_pls_b = 1'b0;
      end else begin
         if (!enable) begin
            rem = 0;
         end else if (rem > 0) begin
            ev[0] = hdr_vld;
            ev[2] = par_bad;
            rem--;
            if (rem == 0) begin
               m_wd = 1'b1; inc_wr = 1'b1;
            end
         end else if (hdr_vld) begin
            ev[2] = par_bad;
            if (!datareq && datareq16) begin
               ev[1] = 1'b1;
            end else begin
               m_hs = 1'b1; m_tag = data[79:64]; m_pa = data[39:0];
               inc_byp = reqbypass;
               if (!datareq) inc_rd = 1'b1;
               else rem = datareq16 ? 1 : PB;
            end
         end
`ifndef NIU_SII_DMA_TRK_PARCHK_EN
         ev[2] = 1'b0;
`endif
         if (clr_stats) begin
            n_rd = 0; n_wr = 0; n_byp = 0;
            m_err_a = 4'h0; m_err_b = 4'h0; m_pls_a = 1'b0; m_pls_b = 1'b0;
         end else begin
            sat_a = (inc_rd && n_rd >= MAX_A) || (inc_wr && n_wr >= MAX_A) || (inc_byp && n_byp >= MAX_A);
            sat_b = (inc_rd && n_rd >= MAX_B) || (inc_wr && n_wr >= MAX_B) || (inc_byp && n_byp >= MAX_B);
            n_rd  += int'(inc_rd);
            n_wr  += int'(inc_wr);
            n_byp += int'(inc_byp);
            m_err_a = m_err_a | {sat_a, ev};
            m_err_b = m_err_b | {sat_b, ev};
            m_pls_a = sat_a || (ev != 3'b000);
            m_pls_b = sat_b || (ev != 3'b000);
         end
      end
   endtask

   // One clock: advance the model, then compare all outputs 1 time unit later.
   task automatic step();
      @(posedge iol2clk);
      model_step();
      #1;
      chk("rd_a",  rd_a,  64'(cap(n_rd,  MAX_A)));
      chk("wr_a",  wr_a,  64'(cap(n_wr,  MAX_A)));
      chk("byp_a", byp_a, 64'(cap(n_byp, MAX_A)));
      chk("tag_a", tag_a, m_tag);
      chk("pa_a",  pa_a,  m_pa);
      chk("hs_a",  hs_a,  m_hs);
      chk("wd_a",  wd_a,  m_wd);
      chk("err_a", err_a, m_err_a);
      chk("pls_a", pls_a, m_pls_a);
      chk("rd_b",  rd_b,  64'(cap(n_rd,  MAX_B)));
      chk("wr_b",  wr_b,  64'(cap(n_wr,  MAX_B)));
      chk("byp_b", byp_b, 64'(cap(n_byp, MAX_B)));
      chk("err_b", err_b, m_err_b);
      chk("pls_b", pls_b, m_pls_b);
   endtask

   // Drive one bus cycle; parity is made correct, then one lane flipped if bad.
   task automatic drive(input logic hv, input logic byp, input logic dr, input logic d16,
                        input logic [15:0] tag, input logic [39:0] pa, input logic bad);
      logic [DATA_W-1:0] d;
      int lane;
      d = {$urandom, $urandom, $urandom, $urandom};
      d[79:64] = tag;
      d[39:0]  = pa;
      data = d; hdr_vld = hv; reqbypass = byp; datareq = dr; datareq16 = d16;
      for (int i = 0; i < LANES; i++) parity[i] = ^d[16*i +: 16];
      if (bad) begin
         lane = int'($urandom_range(LANES - 1, 0));
         parity[lane] = ~parity[lane];
      end
      par_bad = bad;
   endtask

   task automatic idle();
      clr_stats = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 40'h0, 1'b0);
   endtask

   task automatic hdr(input logic dr, input logic d16, input logic byp);
      clr_stats = 1'b0;
      drive(1'b1, byp, dr, d16, 16'($urandom), {8'($urandom), 32'($urandom)}, 1'b0);
   endtask

   task automatic clear();
      idle(); clr_stats = 1'b1; step(); clr_stats = 1'b0;
   endtask

   initial begin
      rem = 0; n_rd = 0; n_wr = 0; n_byp = 0; m_tag = '0; m_pa = '0;
      m_err_a = '0; m_err_b = '0; m_pls_a = 1'b0; m_pls_b = 1'b0; m_hs = 1'b0; m_wd = 1'b0;
      idle();
      rst = 1'b1; step(); step();
      rst = 1'b0; enable = 1'b1;
      step();
      chk("rst_rd", rd_a, 64'd0);
      chk("rst_err", err_a, 64'd0);

      // read header with bypass
      clr_stats = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h00A5, 40'h12_3456_7890, 1'b0);
      step();
      chk("t1_rd", rd_a, 64'd1);
      chk("t1_byp", byp_a, 64'd1);
      chk("t1_tag", tag_a, 64'h00A5);
      chk("t1_pa", pa_a, 64'h12_3456_7890);
      chk("t1_hs", hs_a, 64'd1);
      idle(); step();
      chk("t1_hs_off", hs_a, 64'd0);

      // line write, 4 beats, then read
      clear();
      hdr(1'b1, 1'b0, 1'b0); step();
      for (int b = 0; b < PB; b++) begin idle(); step(); end
      chk("t2_wd", wd_a, 64'd1);
      chk("t2_wr", wr_a, 64'd1);
      hdr(1'b0, 1'b0, 1'b0); step();
      chk("t2_rd", rd_a, 64'd1);

      // 16B write, 1 beat, immediate line write
      clear();
      hdr(1'b1, 1'b1, 1'b0); step();
      idle(); step();
      hdr(1'b1, 1'b0, 1'b0); step();
      for (int b = 0; b < PB; b++) begin idle(); step(); end
      chk("t3_wr", wr_a, 64'd2);
      chk("t3_err", err_a, 64'd0);

      // stray header on beat 2
      clear();
      hdr(1'b1, 1'b0, 1'b0); step();
      idle(); step();
      hdr(1'b0, 1'b0, 1'b0); step();
      chk("t4_pls", pls_a, 64'd1);
      idle(); step();
      chk("t4_pls_off", pls_a, 64'd0);
      idle(); step();
      chk("t4_wd", wd_a, 64'd1);
      chk("t4_err", err_a, 64'b0001);
      chk("t4_rd", rd_a, 64'd0);

      // reserved encoding
      clear();
      hdr(1'b0, 1'b1, 1'b1); step();
      chk("t5_err", err_a, 64'b0010);
      chk("t5_rd", rd_a, 64'd0);
      chk("t5_byp", byp_a, 64'd0);
`ifdef NIU_SII_DMA_TRK_PARCHK_EN
      clr_stats = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 40'h22, 1'b1); step();
      chk("t5_par", err_a[2], 64'd1);
`endif

      // saturation on the narrow instance, then clear
      clear();
      for (int k = 0; k < 4; k++) begin hdr(1'b0, 1'b0, 1'b0); step(); end
      chk("t6_rd_sat", rd_b, 64'd3);
      chk("t6_err_sat", err_b[3], 64'd1);
      clear();
      chk("t6_clr_rd", rd_b, 64'd0);
      chk("t6_clr_err", err_b, 64'd0);

      // reset in the middle of a payload
      hdr(1'b1, 1'b0, 1'b0); step();
      idle(); step(); step();
      rst = 1'b1; step();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin idle(); step(); chk("t7_wd", wd_a, 64'd0); end

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         logic [1:0] enc;
         enc = 2'($urandom);
         clr_stats = 1'b0;
         drive(($urandom % 3) == 0, 1'($urandom), enc[1], enc[0],
               16'($urandom), {8'($urandom), 32'($urandom)}, ($urandom % 12) == 0);
         clr_stats = ($urandom % 40) == 0;
         enable    = ($urandom % 16) != 0;
         rst       = ($urandom % 300) == 0;
         step();
         rst = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/niu_sii_dma_req_tracker.md
Name: niu_sii_dma_req_tracker

Overview:
- Parametrised, synthesizable successor to the NIU→SII inbound DMA monitor.
- Decodes NIU→SII header and payload cycles on the iol2clk domain and tracks write-payload beats with an FSM.
- Keeps saturating read/write/bypass statistics, captures the last header's tag and PA, and flags protocol and parity violations.
- Sits passively on the NIU→SII request bus beside the SII inbound queues and never drives the bus.

Parameters:
- DATA_W, 128: payload/header bus width; multiple of 16, ≥128.
- PAYLOAD_BEATS, 4: data beats for a full-line write ({datareq,datareq16}=2'b10); ≥2.
- CNT_W, 16: width of each statistics counter.

Ports:
- iol2clk  in  1  clock.
- rst  in  1  reset.
- enable  in  1  monitor enable.
- clr_stats  in  1  synchronous clear of counters and sticky errors.
- niu_sii_hdr_vld  in  1  header cycle valid.
- niu_sii_reqbypass  in  1  1=bypass queue, 0=ordered queue.
- niu_sii_datareq  in  1  request carries data.
- niu_sii_datareq16  in  1  16-byte data request.
- niu_sii_data  in  DATA_W  header/payload data.
- niu_sii_parity  in  DATA_W/16  one parity bit per 16-bit lane.
- rd_cnt  out  CNT_W  accepted read headers.
- wr_cnt  out  CNT_W  completed writes.
- byp_cnt  out  CNT_W  accepted headers with reqbypass=1.
- hdr_tag  out  16  data[79:64] of last accepted header.
- hdr_pa  out  40  data[39:0] of last accepted header.
- hdr_strobe  out  1  one-cycle pulse on header accept.
- wr_done  out  1  one-cycle pulse on final write beat.
- err_sticky  out  4  [0] header during payload; [1] reserved encoding; [2] parity; [3] counter saturation.
- err_pulse  out  1  one-cycle pulse when any error bit sets this cycle.

Behaviour:
- Interface (already decided): one clock, iol2clk. rst is asynchronous and active-high.
- Reset: all outputs, counters, captured fields and sticky errors go to 0. FSM goes to IDLE and beat_cnt to 0. Reset mid-payload abandons the write; no wr_done is produced.
- All outputs are registered. Events appear one cycle after the sampled input edge.
- enable=0: FSM forced to IDLE. No counting, no capture, no error setting. Outputs hold their values.
- FSM has two states, IDLE and WDATA.
- IDLE, hdr_vld=1, decoded on {datareq,datareq16}:
  - 00 (read): rd_cnt+1; capture tag/PA; hdr_strobe; stay in IDLE.
  - 10 (line write): capture; hdr_strobe; beat_cnt=PAYLOAD_BEATS; go to WDATA.
  - 11 (16B write): capture; hdr_strobe; beat_cnt=1; go to WDATA.
  - 01 (reserved): set err[1]; no capture; no count; stay in IDLE.
- Accepted header with reqbypass=1: byp_cnt+1 in the same cycle as the header.
- Back-to-back read headers in consecutive cycles are each counted.
- WDATA: every cycle is a payload beat; the first beat is the cycle immediately after the header.
  - Each beat decrements beat_cnt.
  - On the beat where beat_cnt==1: pulse wr_done, wr_cnt+1, go to IDLE.
  - A new header is legal in the cycle after the last beat.
- hdr_vld=1 in WDATA: set err[0]. The cycle still counts as a beat. The header is not captured, counted or decoded.
- Parity: even per lane, i.e. niu_sii_parity[i] must equal ^niu_sii_data[16i+15:16i]. Checked on header cycles and payload beats (see Optional Feature).
- Counters saturate at all-ones. An increment at saturation holds the value and sets err[3].
- clr_stats=1 clears counters and err_sticky. A simultaneous increment or error is lost (clear wins). FSM and captured header are unaffected.
- err_pulse is the OR of error bits newly set this cycle, including re-detections of already-set bits.

Optional Feature:
- Macro NIU_SII_DMA_TRK_PARCHK_EN.
- Defined: per-lane parity checking active; a mismatch sets err[2] and pulses err_pulse.
- Undefined: no parity logic is synthesised; err_sticky[2] is tied to 0; niu_sii_parity is unused.

Test Plan:
- Reset, then read header (hdr_vld=1, {datareq,datareq16}=00, reqbypass=1, data[79:64]=16'h00A5, data[39:0]=40'h12_3456_7890) -> next cycle: rd_cnt=1, byp_cnt=1, hdr_tag=16'h00A5, hdr_pa=40'h1234567890, hdr_strobe pulses for one cycle.
- Line-write header (10) followed by 4 beats -> wr_done pulses exactly on the 4th beat; wr_cnt=1; FSM back in IDLE. A read header in the next cycle gives rd_cnt=1.
- 16B write (11) followed by 1 beat, then an immediate line write -> wr_cnt=2 after 1+1+1+4 cycles; no errors.
- hdr_vld asserted on beat 2 of a line write -> err_sticky=4'b0001, err_pulse pulses once; wr_done still on beat 4; rd_cnt unchanged.
- Reserved encoding 01 -> err_sticky[1]=1, all counters 0. With the macro defined, parity[0] flipped on a header -> err_sticky[2]=1.
- Run with CNT_W=2: 4 reads -> rd_cnt stays 3 and err[3]=1. Then clr_stats -> all counters and err_sticky read 0. Separately, assert rst mid-payload -> FSM in IDLE, no wr_done.
